mips_cpu_bus_arbiter: RTL and testbench



---
 rtl/mips_cpu_bus_arb_pkg.sv | 20 ++
 rtl/mips_cpu_bus_arb_pick.sv | 35 +++
 rtl/mips_cpu_bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mips_cpu_bus_arbiter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_bus_arb_pkg.sv
// Shared types and constants for the CPU memory-bus arbiter.
// State and owner encodings are used by the top sequencer and the grant picker.
package mips_cpu_bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } owner_t;

  localparam int         BUS_DW = 32;
  localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/mips_cpu_bus_arb_pick.sv
// Combinational grant selection between the fetch and load/store requesters.
// MIPS_BUS_ARB_RR_EN selects round-robin on contention; otherwise DATA always wins.
module mips_cpu_bus_arb_pick
  import mips_cpu_bus_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant
);

  always_comb begin
    grant_valid = i_req | d_req;
    grant       = INSTR;
`ifdef MIPS_BUS_ARB_RR_EN
    if (i_req && d_req) begin
      // Whoever was not served last takes the contended slot.
      grant = (last_grant == DATA) ? INSTR : DATA;
    end else if (d_req) begin
      grant = DATA;
    end
`else
    if (d_req) begin
      grant = DATA;
    end
`endif
  end

`ifndef MIPS_BUS_ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/mips_cpu_bus_arbiter.sv
// Shares one Avalon-style memory port between instruction fetch and load/store.
// Arbitration mode is chosen by MIPS_BUS_ARB_RR_EN (round-robin when defined, DATA-first otherwise).
module mips_cpu_bus_arbiter
  import mips_cpu_bus_arb_pkg::*;
#(
  parameter int ADDR_W = 32
)(
  input  logic              clk,
  input  logic              rst_n,

  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_waitrequest,
  output logic [BUS_DW-1:0] i_readdata,

  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_byteenable,
  input  logic [BUS_DW-1:0] d_writedata,
  output logic              d_waitrequest,
  output logic [BUS_DW-1:0] d_readdata,

  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [3:0]        m_byteenable,
  output logic [BUS_DW-1:0] m_writedata,
  input  logic              m_waitrequest,
  input  logic [BUS_DW-1:0] m_readdata
);

  state_t state, state_n;
  owner_t owner, owner_n;
  owner_t last_grant, last_grant_n;

  logic grant_valid;
  logic grant;

  logic              m_read_n;
  logic              m_write_n;
  logic [ADDR_W-1:0] m_addr_n;
  logic [3:0]        m_byteenable_n;
  logic [BUS_DW-1:0] m_writedata_n;
  logic              i_waitrequest_n;
  logic              d_waitrequest_n;
  logic [BUS_DW-1:0] i_readdata_n;
  logic [BUS_DW-1:0] d_readdata_n;

  mips_cpu_bus_arb_pick u_pick (
    .i_req       (i_read),
    .d_req       (d_read | d_write),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // The m_* registers double as the request latches, so the bus sees
  // exactly what was captured in IDLE for the whole transfer.
  always_comb begin
    state_n         = state;
    owner_n         = owner;
    last_grant_n    = last_grant;
    m_read_n        = m_read;
    m_write_n       = m_write;
    m_addr_n        = m_addr;
    m_byteenable_n  = m_byteenable;
    m_writedata_n   = m_writedata;
    i_waitrequest_n = 1'b1;
    d_waitrequest_n = 1'b1;
    i_readdata_n    = i_readdata;
    d_readdata_n    = d_readdata;

    case (state)
      IDLE: begin
        if (grant_valid) begin
          state_n      = ISSUE;
          owner_n      = owner_t'(grant);
          last_grant_n = owner_t'(grant);
          if (grant == DATA) begin
            m_addr_n       = d_addr;
            m_byteenable_n = d_byteenable;
            m_writedata_n  = d_writedata;
            // A simultaneous read+write request is executed as a write only.
            m_write_n      = d_write;
            m_read_n       = ~d_write;
          end else begin
            m_addr_n       = i_addr;
            m_byteenable_n = BE_ALL;
            m_write_n      = 1'b0;
            m_read_n       = 1'b1;
          end
        end
      end

      ISSUE: begin
        if (!m_waitrequest) begin
          m_read_n  = 1'b0;
          m_write_n = 1'b0;
          if (m_read) begin
            state_n = RDATA;
          end else begin
            state_n = RESP;
            if (owner == DATA) d_waitrequest_n = 1'b0;
            else               i_waitrequest_n = 1'b0;
          end
        end
      end

      RDATA: begin
        state_n = RESP;
        if (owner == DATA) begin
          d_readdata_n    = m_readdata;
          d_waitrequest_n = 1'b0;
        end else begin
          i_readdata_n    = m_readdata;
          i_waitrequest_n = 1'b0;
        end
      end

      RESP: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      owner         <= INSTR;
      last_grant    <= INSTR;
      m_read        <= 1'b0;
      m_write       <= 1'b0;
      m_addr        <= '0;
      m_byteenable  <= '0;
      m_writedata   <= '0;
      i_waitrequest <= 1'b1;
      d_waitrequest <= 1'b1;
      i_readdata    <= '0;
      d_readdata    <= '0;
    end else begin
      state         <= state_n;
      owner         <= owner_n;
      last_grant    <= last_grant_n;
      m_read        <= m_read_n;
      m_write       <= m_write_n;
      m_addr        <= m_addr_n;
      m_byteenable  <= m_byteenable_n;
      m_writedata   <= m_writedata_n;
      i_waitrequest <= i_waitrequest_n;
      d_waitrequest <= d_waitrequest_n;
      i_readdata    <= i_readdata_n;
      d_readdata    <= d_readdata_n;
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Scoreboard bench for mips_cpu_bus_arbiter: requester tasks push expectations,
// independent monitors on the requester and memory sides pop and compare.
module tb_mips_cpu_bus_arbiter;

  localparam int TIMEOUT = 3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_read = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_waitrequest;
  logic [31:0] i_readdata;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_addr = '0;
  logic [3:0]  d_byteenable = '0;
  logic [31:0] d_writedata = '0;
  logic        d_waitrequest;
  logic [31:0] d_readdata;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_addr;
  logic [3:0]  m_byteenable;
  logic [31:0] m_writedata;
  logic        m_waitrequest = 1'b0;
  logic [31:0] m_readdata = '0;

  always #5 clk = ~clk;

  mips_cpu_bus_arbiter #(.ADDR_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_read        (i_read),
    .i_addr        (i_addr),
    .i_waitrequest (i_waitrequest),
    .i_readdata    (i_readdata),
    .d_read        (d_read),
    .d_write       (d_write),
    .d_addr        (d_addr),
    .d_byteenable  (d_byteenable),
    .d_writedata   (d_writedata),
    .d_waitrequest (d_waitrequest),
    .d_readdata    (d_readdata),
    .m_read        (m_read),
    .m_write       (m_write),
    .m_addr        (m_addr),
    .m_byteenable  (m_byteenable),
    .m_writedata   (m_writedata),
    .m_waitrequest (m_waitrequest),
    .m_readdata    (m_readdata)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } dexp_t;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_i_q[$];
  logic [31:0] exp_ibus_q[$];
  dexp_t       exp_d_q[$];
  dexp_t       exp_dbus_q[$];
  logic [7:0]  grant_log[$];

  logic [31:0] model_mem[logic [31:0]];
  logic [31:0] bus_mem[logic [31:0]];

  int stall_pct = 0;
  int stall_left = 0;
  int active_len = 0;
  int last_active_len = 0;
  int m_read_cycles = 0;
  int d_done = 0;

  // Reference memory contents: fetch region is a fixed ROM, data region starts
  // from an address-derived pattern and is updated by byte-lane writes.
  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'hBFC00000) return 32'h3C011234;
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hA5A50000 ^ {a[7:0], 24'h0};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] bus_rd(input logic [31:0] a);
    if (a[31:20] == 12'hBFC) return rom(a);
    return bus_mem.exists(a) ? bus_mem[a] : dflt(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  task automatic report_fail(input string name, input string what);
    n_checks++;
    $display("FAIL %s: %s", name, what);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_m_read"},   32'(m_read), 32'h0);
    check({tag, "_m_write"},  32'(m_write), 32'h0);
    check({tag, "_m_addr"},   m_addr, 32'h0);
    check({tag, "_m_be"},     32'(m_byteenable), 32'h0);
    check({tag, "_m_wdata"},  m_writedata, 32'h0);
    check({tag, "_i_wait"},   32'(i_waitrequest), 32'h1);
    check({tag, "_d_wait"},   32'(d_waitrequest), 32'h1);
    check({tag, "_i_rdata"},  i_readdata, 32'h0);
    check({tag, "_d_rdata"},  d_readdata, 32'h0);
  endtask

  task automatic fetch(input logic [31:0] a, output int lat);
    exp_i_q.push_back(rom(a));
    exp_ibus_q.push_back(a);
    i_addr = a;
    i_read = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (i_waitrequest && lat < TIMEOUT);
    if (i_waitrequest) report_fail("fetch_timeout", "no i_waitrequest=0 within cycle budget");
    @(posedge clk);
    #1;
    i_read = 1'b0;
  endtask

  task automatic data_op(input bit rd, input bit wr, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd, output int lat);
    dexp_t e;
    e.wr = wr;
    e.addr = a;
    e.be = be;
    e.wdata = wd;
    e.rdata = model_rd(a);
    if (wr) model_mem[a] = merge(model_rd(a), wd, be);
    exp_d_q.push_back(e);
    exp_dbus_q.push_back(e);
    d_addr = a;
    d_byteenable = be;
    d_writedata = wd;
    d_read = rd;
    d_write = wr;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (d_waitrequest && lat < TIMEOUT);
    if (d_waitrequest) report_fail("data_timeout", "no d_waitrequest=0 within cycle budget");
    @(posedge clk);
    #1;
    d_read = 1'b0;
    d_write = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Requester-side monitor: completions must match queued expectations.
  bit    prev_i_low = 1'b0;
  bit    prev_d_low = 1'b0;
  dexp_t mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_i_low = 1'b0;
      prev_d_low = 1'b0;
    end else begin
      if (!i_waitrequest) begin
        if (prev_i_low) report_fail("i_wait_pulse", "i_waitrequest low two cycles running, required one");
        if (exp_i_q.size() == 0) report_fail("i_unexpected", "fetch completion with nothing outstanding");
        else check("i_readdata", i_readdata, exp_i_q.pop_front());
      end
      if (!d_waitrequest) begin
        if (prev_d_low) report_fail("d_wait_pulse", "d_waitrequest low two cycles running, required one");
        if (exp_d_q.size() == 0) report_fail("d_unexpected", "data completion with nothing outstanding");
        else begin
          mon_e = exp_d_q.pop_front();
          if (!mon_e.wr) check("d_readdata", d_readdata, mon_e.rdata);
        end
      end
      if (!i_waitrequest && !d_waitrequest)
        report_fail("both_wait_low", "both waitrequests low together");
      prev_i_low = !i_waitrequest;
      prev_d_low = !d_waitrequest;
    end
  end

  // Memory-side model: stalls, returns read data the cycle after acceptance,
  // and checks each accepted transfer against the requester's expectation.
  bit          acc_rd;
  logic [31:0] acc_addr;
  bit          have_prev = 1'b0;
  logic        p_rd, p_wr;
  logic [31:0] p_addr, p_wd;
  logic [3:0]  p_be;
  logic [31:0] bus_ea;
  dexp_t       bus_e;
  always begin
    @(negedge clk);
    acc_rd = 1'b0;
    if (!rst_n) begin
      have_prev = 1'b0;
      active_len = 0;
    end else if (m_read || m_write) begin
      active_len++;
      if (m_read) m_read_cycles++;
      if (m_read && m_write) report_fail("bus_excl", "m_read and m_write high together");
      if (have_prev) begin
        check("stall_addr", m_addr, p_addr);
        check("stall_be", 32'(m_byteenable), 32'(p_be));
        check("stall_wdata", m_writedata, p_wd);
        check("stall_dir", {30'h0, m_read, m_write}, {30'h0, p_rd, p_wr});
      end
      if (!m_waitrequest) begin
        if (m_addr[31:20] == 12'hBFC) begin
          grant_log.push_back("I");
          if (exp_ibus_q.size() == 0) report_fail("ibus_unexpected", "fetch transfer not requested");
          else begin
            bus_ea = exp_ibus_q.pop_front();
            check("ibus_addr", m_addr, bus_ea);
            check("ibus_be", 32'(m_byteenable), 32'hF);
            check("ibus_read", {30'h0, m_read, m_write}, 32'h2);
          end
        end else begin
          grant_log.push_back("D");
          if (exp_dbus_q.size() == 0) report_fail("dbus_unexpected", "data transfer not requested");
          else begin
            bus_e = exp_dbus_q.pop_front();
            check("dbus_addr", m_addr, bus_e.addr);
            check("dbus_be", 32'(m_byteenable), 32'(bus_e.be));
            check("dbus_dir", {30'h0, m_read, m_write}, bus_e.wr ? 32'h1 : 32'h2);
            if (bus_e.wr) check("dbus_wdata", m_writedata, bus_e.wdata);
          end
          if (m_write) bus_mem[m_addr] = merge(bus_rd(m_addr), m_writedata, m_byteenable);
        end
        acc_rd = m_read;
        acc_addr = m_addr;
        last_active_len = active_len;
        active_len = 0;
        have_prev = 1'b0;
      end else begin
        have_prev = 1'b1;
        p_rd = m_read;
        p_wr = m_write;
        p_addr = m_addr;
        p_be = m_byteenable;
        p_wd = m_writedata;
      end
    end else begin
      have_prev = 1'b0;
      active_len = 0;
    end
    @(posedge clk);
    #1;
    m_readdata = acc_rd ? bus_rd(acc_addr) : $urandom;
    if ((m_read || m_write) && stall_left > 0) begin
      m_waitrequest = 1'b1;
      stall_left--;
    end else begin
      m_waitrequest = (int'($urandom_range(0, 99)) < stall_pct);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  int         lat, lat_a, lat_b, snap;
  logic [7:0] exp_order[4];

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    rst_n = 1'b1;

    fetch(32'hBFC00000, lat);
    check("fetch_latency", 32'(lat), 32'd4);

    stall_left = 2;
    data_op(1'b0, 1'b1, 32'h00001000, 4'b0011, 32'hDEADBEEF, lat);
    check("write_latency", 32'(lat), 32'd5);
    check("write_strobe_len", 32'(last_active_len), 32'd3);
    data_op(1'b1, 1'b0, 32'h00001000, 4'hF, 32'h0, lat);
    check("read_latency", 32'(lat), 32'd4);

    m_read_cycles = 0;
    data_op(1'b1, 1'b1, 32'h00001004, 4'b1100, 32'h12345678, lat);
    check("rw_no_mread", 32'(m_read_cycles), 32'd0);
    check("rw_latency", 32'(lat), 32'd3);
    data_op(1'b1, 1'b0, 32'h00001004, 4'hF, 32'h0, lat);

    do_reset();
    grant_log.delete();
    fork
      begin
        fetch(32'hBFC00010, lat_a);
        fetch(32'hBFC00014, lat_a);
      end
      begin
        data_op(1'b1, 1'b0, 32'h00001008, 4'hF, 32'h0, lat_b);
        data_op(1'b1, 1'b0, 32'h0000100C, 4'hF, 32'h0, lat_b);
      end
    join
`ifdef MIPS_BUS_ARB_RR_EN
    exp_order = '{"D", "I", "D", "I"};
`else
    exp_order = '{"D", "D", "I", "I"};
`endif
    check("order_count", 32'(grant_log.size()), 32'd4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      check("grant_order", 32'(grant_log[k]), 32'(exp_order[k]));

    do_reset();
    d_done = 0;
    fork
      begin
        fetch(32'hBFC00030, lat_a);
        snap = d_done;
      end
      begin
        for (int k = 0; k < 5; k++) begin
          data_op(1'b1, 1'b0, 32'h00001010 + 32'(4 * k), 4'hF, 32'h0, lat_b);
          d_done++;
        end
      end
    join
`ifdef MIPS_BUS_ARB_RR_EN
    check("rr_fetch_after", 32'(snap), 32'd1);
`else
    check("fixed_fetch_after", 32'(snap), 32'd5);
`endif

    stall_left = 1000;
    i_addr = 32'hBFC00020;
    i_read = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("issue_mread", 32'(m_read), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    i_read = 1'b0;
    stall_left = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fetch(32'hBFC00024, lat);
    check("post_rst_latency", 32'(lat), 32'd4);

    stall_pct = 30;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          fetch(32'hBFC00000 + 32'($urandom_range(0, 255)) * 4, lat_a);
        end
      end
      begin
        for (int k = 0; k < 40; k++) begin
          int unsigned kind;
          kind = $urandom_range(0, 2);
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
          end
          data_op(kind != 1, kind != 0, 32'h00001000 + 32'($urandom_range(0, 15)) * 4,
                  4'($urandom_range(0, 15)), $urandom, lat_b);
        end
      end
    join
    stall_pct = 0;
    repeat (5) @(posedge clk);
    #1;
    check("i_resp_drained", 32'(exp_i_q.size()), 32'd0);
    check("d_resp_drained", 32'(exp_d_q.size()), 32'd0);
    check("ibus_drained", 32'(exp_ibus_q.size()), 32'd0);
    check("dbus_drained", 32'(exp_dbus_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
